// File: rtl/manage_tx_arb.sv
// Round-robin arbiter moving whole packets from NCH show-ahead channel FIFOs
// into one downstream FIFO, forwarding or dropping each according to its valid flag.
//
//   state | meaning
//   IDLE  | wait for an eligible channel and room downstream; grant pops its valid flag
//   PASS  | pop granted channel each cycle and write the word downstream
//   DROP  | pop granted channel each cycle, discard the word
//   GAP   | one idle cycle so tx_pkt_usedw settles before the next threshold check
module manage_tx_arb #(
  parameter int NCH       = 4,
  parameter int USEDW_W   = 8,
  parameter int TX_THRESH = 161,
  parameter int CNT_W     = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NCH*139-1:0]     in_pkt_q,
  output logic [NCH-1:0]         in_pkt_rdreq,
  input  logic [NCH-1:0]         in_valid_q,
  input  logic [NCH-1:0]         in_valid_empty,
  output logic [NCH-1:0]         in_valid_rdreq,
  input  logic [NCH-1:0]         chan_en,
  output logic [138:0]           tx_pkt,
  output logic                   tx_pkt_wrreq,
  output logic                   tx_pkt_valid,
  output logic                   tx_pkt_valid_wrreq,
  input  logic [USEDW_W-1:0]     tx_pkt_usedw,
  output logic [NCH*CNT_W-1:0]   pkt_cnt,
  output logic [NCH*CNT_W-1:0]   drop_cnt
);

  localparam int GW = $clog2(NCH);
  localparam logic [USEDW_W-1:0] THRESH = USEDW_W'(TX_THRESH);

  typedef enum logic [1:0] {IDLE, PASS, DROP, GAP} state_t;

  state_t                        state_q, state_d;
  logic [GW-1:0]                 last_grant_q, last_grant_d;
  logic [138:0]                  tx_pkt_q, tx_pkt_d;
  logic                          tx_pkt_wrreq_q, tx_pkt_wrreq_d;
  logic                          tx_pkt_valid_q, tx_pkt_valid_d;
  logic                          tx_pkt_valid_wrreq_q, tx_pkt_valid_wrreq_d;
  logic [NCH-1:0][CNT_W-1:0]     pkt_cnt_q, pkt_cnt_d;
  logic [NCH-1:0][CNT_W-1:0]     drop_cnt_q, drop_cnt_d;

  logic [NCH-1:0]                eligible;
  logic                          found;
  logic [GW-1:0]                 cand;
  logic [GW-1:0]                 grant_idx;
  logic [138:0]                  cur_word;
  logic                          is_tail;
  logic [NCH-1:0]                pkt_rd;
  logic [NCH-1:0]                valid_rd;

  assign eligible = ~in_valid_empty & chan_en;
  assign cur_word = in_pkt_q[int'(last_grant_q)*139 +: 139];
  assign is_tail  = (cur_word[138:136] == 3'b110);

  // Round-robin search starting just after the previous grant.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 1; k <= NCH; k++) begin
      cand = GW'((int'(last_grant_q) + k) % NCH);
      if (!found && eligible[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_comb begin
    state_d              = state_q;
    last_grant_d         = last_grant_q;
    tx_pkt_d             = tx_pkt_q;
    tx_pkt_wrreq_d       = 1'b0;
    tx_pkt_valid_d       = 1'b0;
    tx_pkt_valid_wrreq_d = 1'b0;
    pkt_cnt_d            = pkt_cnt_q;
    drop_cnt_d           = drop_cnt_q;
    pkt_rd               = '0;
    valid_rd             = '0;
    case (state_q)
      IDLE: begin
        if (found && (tx_pkt_usedw <= THRESH)) begin
          valid_rd[grant_idx] = 1'b1;
          last_grant_d        = grant_idx;
          state_d             = in_valid_q[grant_idx] ? PASS : DROP;
        end
      end
      PASS: begin
        pkt_rd[last_grant_q] = 1'b1;
        tx_pkt_d             = cur_word;
        tx_pkt_wrreq_d       = 1'b1;
        if (is_tail) begin
          tx_pkt_valid_d          = 1'b1;
          tx_pkt_valid_wrreq_d    = 1'b1;
          pkt_cnt_d[last_grant_q] = pkt_cnt_q[last_grant_q] + CNT_W'(1);
          state_d                 = GAP;
        end
      end
      DROP: begin
        pkt_rd[last_grant_q] = 1'b1;
        if (is_tail) begin
          drop_cnt_d[last_grant_q] = drop_cnt_q[last_grant_q] + CNT_W'(1);
          state_d                  = GAP;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q              <= IDLE;
      last_grant_q         <= GW'(NCH - 1);
      tx_pkt_q             <= '0;
      tx_pkt_wrreq_q       <= 1'b0;
      tx_pkt_valid_q       <= 1'b0;
      tx_pkt_valid_wrreq_q <= 1'b0;
      pkt_cnt_q            <= '0;
      drop_cnt_q           <= '0;
    end else begin
      state_q              <= state_d;
      last_grant_q         <= last_grant_d;
      tx_pkt_q             <= tx_pkt_d;
      tx_pkt_wrreq_q       <= tx_pkt_wrreq_d;
      tx_pkt_valid_q       <= tx_pkt_valid_d;
      tx_pkt_valid_wrreq_q <= tx_pkt_valid_wrreq_d;
      pkt_cnt_q            <= pkt_cnt_d;
      drop_cnt_q           <= drop_cnt_d;
    end
  end

  // FIFO pops are held off while reset is asserted.
  assign in_pkt_rdreq       = pkt_rd & {NCH{reset_n}};
  assign in_valid_rdreq     = valid_rd & {NCH{reset_n}};
  assign tx_pkt             = tx_pkt_q;
  assign tx_pkt_wrreq       = tx_pkt_wrreq_q;
  assign tx_pkt_valid       = tx_pkt_valid_q;
  assign tx_pkt_valid_wrreq = tx_pkt_valid_wrreq_q;
  assign pkt_cnt            = pkt_cnt_q;
  assign drop_cnt           = drop_cnt_q;

endmodule

// File: tb/tb_manage_tx_arb.sv
// Directed bench for manage_tx_arb: behavioural channel FIFOs feed the arbiter,
// each step checks outputs against hand-derived cycle expectations.
module tb_manage_tx_arb;

  logic               clk = 1'b0;
  logic               reset_n;
  logic [4*139-1:0]   in_pkt_q;
  logic [3:0]         in_pkt_rdreq;
  logic [3:0]         in_valid_q;
  logic [3:0]         in_valid_empty;
  logic [3:0]         in_valid_rdreq;
  logic [3:0]         chan_en;
  logic [138:0]       tx_pkt;
  logic               tx_pkt_wrreq;
  logic               tx_pkt_valid;
  logic               tx_pkt_valid_wrreq;
  logic [7:0]         tx_pkt_usedw;
  logic [127:0]       pkt_cnt;
  logic [127:0]       drop_cnt;

  int n_chk  = 0;
  int n_fail = 0;
  int exp_pkt[4];
  int exp_drop[4];

  logic [138:0] pmem [4][64];
  logic         vmem [4][64];
  int pwp[4];
  int prp[4];
  int vwp[4];
  int vrp[4];

  manage_tx_arb dut (
    .clk(clk), .reset_n(reset_n),
    .in_pkt_q(in_pkt_q), .in_pkt_rdreq(in_pkt_rdreq),
    .in_valid_q(in_valid_q), .in_valid_empty(in_valid_empty),
    .in_valid_rdreq(in_valid_rdreq), .chan_en(chan_en),
    .tx_pkt(tx_pkt), .tx_pkt_wrreq(tx_pkt_wrreq),
    .tx_pkt_valid(tx_pkt_valid), .tx_pkt_valid_wrreq(tx_pkt_valid_wrreq),
    .tx_pkt_usedw(tx_pkt_usedw), .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // Show-ahead FIFO models: head word visible, pop on rdreq at the clock edge.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      in_pkt_q[i*139 +: 139] = pmem[i][prp[i]];
      in_valid_q[i]          = vmem[i][vrp[i]];
      in_valid_empty[i]      = (vwp[i] == vrp[i]);
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (in_pkt_rdreq[i])   prp[i] <= prp[i] + 1;
      if (in_valid_rdreq[i]) vrp[i] <= vrp[i] + 1;
    end
  end

  function automatic logic [138:0] mkword(input int ch, input int id, input int k, input int len);
    logic [2:0] tag;
    tag = (k == 0) ? 3'b101 : ((k == len - 1) ? 3'b110 : 3'b100);
    return {tag, 8'(ch), 8'(id), 8'(k), 112'(k * 7919 + id * 31 + ch)};
  endfunction

  task automatic chk(input string tag, input logic [138:0] obs, input logic [138:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_pkt(input int ch, input int id, input int len, input logic vld);
    for (int k = 0; k < len; k++) begin
      pmem[ch][pwp[ch]] = mkword(ch, id, k, len);
      pwp[ch] = pwp[ch] + 1;
    end
    vmem[ch][vwp[ch]] = vld;
    vwp[ch] = vwp[ch] + 1;
  endtask

  // Next negedge must be the grant cycle; mid_* are applied once the packet is under way.
  task automatic run_pkt(input int ch, input int id, input int len, input logic pass,
                         input logic [7:0] mid_usedw, input logic [3:0] mid_en);
    logic [3:0] onehot;
    onehot = 4'(1 << ch);
    @(negedge clk); #1;
    chk("grant_valid_rdreq", in_valid_rdreq, onehot);
    chk("grant_pkt_rdreq", in_pkt_rdreq, 0);
    chk("grant_wrreq", tx_pkt_wrreq, 0);
    chk("grant_valid_wrreq", tx_pkt_valid_wrreq, 0);
    for (int k = 0; k < len; k++) begin
      @(negedge clk); #1;
      chk("pop_pkt_rdreq", in_pkt_rdreq, onehot);
      chk("pop_valid_rdreq", in_valid_rdreq, 0);
      chk("pop_wrreq", tx_pkt_wrreq, pass && (k > 0));
      chk("pop_valid_wrreq", tx_pkt_valid_wrreq, 0);
      if (pass && (k > 0)) chk("pop_data", tx_pkt, mkword(ch, id, k - 1, len));
      if (k == 0) begin
        tx_pkt_usedw = mid_usedw;
        chan_en      = mid_en;
      end
    end
    @(negedge clk); #1;
    if (pass) exp_pkt[ch]++;
    else      exp_drop[ch]++;
    chk("gap_pkt_rdreq", in_pkt_rdreq, 0);
    chk("tail_wrreq", tx_pkt_wrreq, pass);
    chk("tail_valid_wrreq", tx_pkt_valid_wrreq, pass);
    chk("tail_valid", tx_pkt_valid, pass);
    if (pass) chk("tail_data", tx_pkt, mkword(ch, id, len - 1, len));
    chk("pkt_cnt", pkt_cnt[ch*32 +: 32], exp_pkt[ch]);
    chk("drop_cnt", drop_cnt[ch*32 +: 32], exp_drop[ch]);
  endtask

  initial begin
    reset_n      = 1'b0;
    chan_en      = 4'hF;
    tx_pkt_usedw = 8'd0;
    for (int i = 0; i < 4; i++) begin
      exp_pkt[i] = 0; exp_drop[i] = 0;
    end
    #2;
    chk("rst_tx_pkt", tx_pkt, 0);
    chk("rst_wrreq", tx_pkt_wrreq, 0);
    chk("rst_valid", tx_pkt_valid, 0);
    chk("rst_valid_wrreq", tx_pkt_valid_wrreq, 0);
    chk("rst_pkt_cnt", pkt_cnt, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    @(negedge clk); #1;
    reset_n = 1'b1;

    // All four channels loaded: round-robin from channel 0, then refilled channel 0.
    @(posedge clk); #1;
    for (int c = 0; c < 4; c++) push_pkt(c, c + 1, 2, 1'b1);
    for (int c = 0; c < 4; c++) run_pkt(c, c + 1, 2, 1'b1, 8'd0, 4'hF);
    @(posedge clk); #1;
    chk("idle_valid_rdreq", in_valid_rdreq, 0);
    push_pkt(0, 5, 2, 1'b1);
    run_pkt(0, 5, 2, 1'b1, 8'd0, 4'hF);

    // Channel 0 four-word forward; chan_en[0] dropped mid-packet must not abort it.
    @(posedge clk); #1;
    push_pkt(0, 6, 4, 1'b1);
    run_pkt(0, 6, 4, 1'b1, 8'd0, 4'b1110);
    chan_en = 4'hF;

    // Channel 2 three-word drop.
    @(posedge clk); #1;
    push_pkt(2, 7, 3, 1'b0);
    run_pkt(2, 7, 3, 1'b0, 8'd0, 4'hF);

    // Threshold: 162 blocks, 161 grants, 200 mid-packet does not abort.
    @(posedge clk); #1;
    tx_pkt_usedw = 8'd162;
    push_pkt(1, 8, 4, 1'b1);
    repeat (3) begin
      @(negedge clk); #1;
      chk("thresh_block_vrd", in_valid_rdreq, 0);
      chk("thresh_block_prd", in_pkt_rdreq, 0);
    end
    @(posedge clk); #1;
    tx_pkt_usedw = 8'd161;
    run_pkt(1, 8, 4, 1'b1, 8'd200, 4'hF);
    tx_pkt_usedw = 8'd0;

    // chan_en[1]=0 with channels 1 and 3 pending: 3 wins, 1 waits for enable.
    @(posedge clk); #1;
    chan_en = 4'b1101;
    push_pkt(1, 9, 2, 1'b1);
    push_pkt(3, 10, 2, 1'b1);
    run_pkt(3, 10, 2, 1'b1, 8'd0, 4'b1101);
    repeat (3) begin
      @(negedge clk); #1;
      chk("disabled_vrd", in_valid_rdreq, 0);
    end
    @(posedge clk); #1;
    chan_en = 4'hF;
    run_pkt(1, 9, 2, 1'b1, 8'd0, 4'hF);

    // Reset asserted on the third word of a six-word packet.
    @(posedge clk); #1;
    push_pkt(0, 11, 6, 1'b1);
    @(negedge clk); #1;
    chk("rstpkt_grant", in_valid_rdreq, 4'b0001);
    repeat (3) @(negedge clk);
    #1;
    chk("rstpkt_third_pop", in_pkt_rdreq, 4'b0001);
    chk("rstpkt_second_word", tx_pkt, mkword(0, 11, 1, 6));
    reset_n = 1'b0;
    #1;
    chk("midrst_tx_pkt", tx_pkt, 0);
    chk("midrst_wrreq", tx_pkt_wrreq, 0);
    chk("midrst_valid", tx_pkt_valid, 0);
    chk("midrst_valid_wrreq", tx_pkt_valid_wrreq, 0);
    chk("midrst_pkt_rdreq", in_pkt_rdreq, 0);
    chk("midrst_valid_rdreq", in_valid_rdreq, 0);
    chk("midrst_pkt_cnt", pkt_cnt, 0);
    chk("midrst_drop_cnt", drop_cnt, 0);
    @(negedge clk); #1;
    reset_n = 1'b1;
    repeat (2) begin
      @(negedge clk); #1;
      chk("postrst_pkt_rdreq", in_pkt_rdreq, 0);
      chk("postrst_valid_rdreq", in_valid_rdreq, 0);
      chk("postrst_wrreq", tx_pkt_wrreq, 0);
      chk("postrst_pkt_cnt", pkt_cnt, 0);
      chk("postrst_drop_cnt", drop_cnt, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
